imem_loader: RTL

Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into the instruction memory's write port. The processor core is held in reset until the whole image has been written. It sits between the host/UART byte source and the `inst_mem` write side, next to the PC/core reset path.

---
 rtl/imem_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: byte stream -> little-endian words -> instruction memory writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int          WORDS     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE,
    S_DONE, S_ERR, S_CHK
  } state_t;
  localparam state_t S_FIN = S_CHK;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE,
    S_DONE, S_ERR
  } state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  localparam logic [16:0] MAX_N = 17'(WORDS);

  state_t      state;
  state_t      state_n;
  logic [1:0]  byte_cnt;
  logic [15:0] len;
  logic [15:0] idx;
  logic [31:0] word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q;
`endif

  logic        xfer;
  logic        restart;
  logic [15:0] len_full;
  logic [15:0] idx_next;

  assign xfer     = in_valid && in_ready;
  assign len_full = {in_byte, len[7:0]};
  assign idx_next = idx + 16'd1;
  assign restart  = start && (state == S_IDLE ||
                              state == S_DONE ||
                              state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    we       = 1'b0;
    core_rst = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (xfer && byte_cnt[0]) begin
          if ({1'b0, len_full} > MAX_N)
            state_n = S_ERR;
          else if (len_full == 16'd0)
            state_n = S_FIN;
          else
            state_n = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (xfer && byte_cnt == 2'd3)
          state_n = S_WRITE;
      end
      S_WRITE: begin
        we      = 1'b1;
        state_n = (idx_next == len) ? S_FIN : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (xfer)
          state_n = (in_byte == xor_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
        if (start) state_n = S_LEN;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) state_n = S_LEN;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      len      <= 16'd0;
      idx      <= 16'd0;
      word_q   <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q    <= 8'd0;
`endif
    end else begin
      if (restart) begin
        byte_cnt <= 2'd0;
        idx      <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q    <= 8'd0;
`endif
      end
      if (xfer) begin
        // length bytes leave the counter at 0 so DATA starts on a word boundary
        if (state == S_LEN && byte_cnt[0])
          byte_cnt <= 2'd0;
        else
          byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q <= xor_q ^ in_byte;
`endif
        if (state == S_LEN) begin
          if (byte_cnt[0]) len[15:8] <= in_byte;
          else             len[7:0]  <= in_byte;
        end
        if (state == S_DATA)
          word_q <= {in_byte, word_q[31:8]};
      end
      if (state == S_WRITE)
        idx <= idx_next;
    end
  end

  assign wdata = word_q;
  assign waddr = BASE_ADDR + {14'd0, idx, 2'b00};

endmodule
